// File: rtl/bus2reg_arb_pkg.sv
// Shared types and constants for the Bus2Reg requester arbiter.
//   state_e   : transaction FSM states (idle, issue, wait, response)
//   bus_req_t : one requester's access record at the default 32-bit bus width
//   DEFAULT_TIMEOUT : default watchdog length in WAIT cycles
package bus2reg_arb_pkg;

    localparam int unsigned REQ_ADDR_W      = 32;
    localparam int unsigned REQ_DATA_W      = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 256;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    typedef struct packed {
        logic                  is_wr;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wr_data;
        logic [REQ_DATA_W-1:0] wr_biten;
    } bus_req_t;

endpackage

// File: rtl/bus2reg_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index of the last winner; search starts at ptr_i+1 (mod NUM_REQ)
//   gnt_o   : one-hot winner (all zero when nothing requests)
//   idx_o   : binary winner index
//   valid_o : at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               valid_o
);

    // One extra bit so ptr + k (at most 2*NUM_REQ-1) never overflows before wrapping.
    localparam int unsigned SumW = IdxW + 1;

    logic [SumW-1:0] sum;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + SumW'(k);
            if (sum >= SumW'(NUM_REQ)) begin
                sum = sum - SumW'(NUM_REQ);
            end
            cand = sum[IdxW-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus2reg_arbiter.sv
// Shares one Bus2Reg register-map port between NUM_REQ requesters.
// Round-robin arbitration, one outstanding transaction, response watchdog.
//   clk_i / rst_i          : clock, asynchronous active-high reset
//   m_*_i                  : per-requester request level and attributes
//   m_ready_o              : one-cycle completion pulse to the granted requester
//   m_rd_data_o / m_err_o  : shared response, zero unless m_ready_o is set
//   s_bus_*_o              : registered request towards the register map
//   s_bus_ready_i etc.     : register-map response
module bus2reg_arbiter
    import bus2reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   m_req_i,
    input  logic [NUM_REQ-1:0]                   m_req_is_wr_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   m_wr_data_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   m_wr_biten_i,
    output logic [NUM_REQ-1:0]                   m_ready_o,
    output logic [DATA_WIDTH-1:0]                m_rd_data_o,
    output logic                                 m_err_o,
    output logic                                 s_bus_req_o,
    output logic                                 s_bus_req_is_wr_o,
    output logic [ADDR_WIDTH-1:0]                s_bus_addr_o,
    output logic [DATA_WIDTH-1:0]                s_bus_wr_data_o,
    output logic [DATA_WIDTH-1:0]                s_bus_wr_biten_o,
    output logic                                 s_bus_req_stall_wr_o,
    output logic                                 s_bus_req_stall_rd_o,
    input  logic                                 s_bus_ready_i,
    input  logic [DATA_WIDTH-1:0]                s_bus_rd_data_i,
    input  logic                                 s_bus_err_i
);

    localparam int unsigned IdxW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_e                state_q;
    logic [IdxW-1:0]       ptr_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [CntW-1:0]       cnt_q;
    logic                  s_bus_req_q;
    logic                  s_bus_req_is_wr_q;
    logic [ADDR_WIDTH-1:0] s_bus_addr_q;
    logic [DATA_WIDTH-1:0] s_bus_wr_data_q;
    logic [DATA_WIDTH-1:0] s_bus_wr_biten_q;
    logic                  stall_q;
    logic [NUM_REQ-1:0]    m_ready_q;
    logic [DATA_WIDTH-1:0] m_rd_data_q;
    logic                  m_err_q;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IdxW-1:0]       arb_idx;
    logic                  arb_valid;

    logic                  timeout_hit;
    logic                  resp_done;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_rr_arbiter (
        .req_i   (m_req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // The counter holds the number of completed WAIT cycles, so the last permitted
    // WAIT cycle is the one entered with TIMEOUT_CYCLES-1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == StWait) &&
                         (cnt_q == CntW'(TimeoutLast));

    // Response selection; ready has priority over a coincident timeout.
    always_comb begin
        resp_done = 1'b0;
        resp_data = '0;
        resp_err  = 1'b0;
        if ((state_q == StIssue) || (state_q == StWait)) begin
            if (s_bus_ready_i) begin
                resp_done = 1'b1;
                resp_data = s_bus_rd_data_i;
                resp_err  = s_bus_err_i;
            end else if (timeout_hit) begin
                resp_done = 1'b1;
                resp_err  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q           <= StIdle;
            ptr_q             <= IdxW'(NUM_REQ - 1);
            gnt_q             <= '0;
            cnt_q             <= '0;
            s_bus_req_q       <= 1'b0;
            s_bus_req_is_wr_q <= 1'b0;
            s_bus_addr_q      <= '0;
            s_bus_wr_data_q   <= '0;
            s_bus_wr_biten_q  <= '0;
            stall_q           <= 1'b0;
            m_ready_q         <= '0;
            m_rd_data_q       <= '0;
            m_err_q           <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        gnt_q             <= arb_gnt;
                        ptr_q             <= arb_idx;
                        s_bus_req_is_wr_q <= m_req_is_wr_i[arb_idx];
                        s_bus_addr_q      <= m_addr_i[arb_idx];
                        s_bus_wr_data_q   <= m_wr_data_i[arb_idx];
                        s_bus_wr_biten_q  <= m_wr_biten_i[arb_idx];
                        s_bus_req_q       <= 1'b1;
                        stall_q           <= 1'b1;
                        state_q           <= StIssue;
                    end
                end
                StIssue, StWait: begin
                    s_bus_req_q <= 1'b0;
                    cnt_q       <= (state_q == StIssue) ? '0 : cnt_q + CntW'(1);
                    if (resp_done) begin
                        m_ready_q   <= gnt_q;
                        m_rd_data_q <= resp_data;
                        m_err_q     <= resp_err;
                        stall_q     <= 1'b0;
                        state_q     <= StResp;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StResp: begin
                    m_ready_q   <= '0;
                    m_rd_data_q <= '0;
                    m_err_q     <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_ready_o            = m_ready_q;
    assign m_rd_data_o          = m_rd_data_q;
    assign m_err_o              = m_err_q;
    assign s_bus_req_o          = s_bus_req_q;
    assign s_bus_req_is_wr_o    = s_bus_req_is_wr_q;
    assign s_bus_addr_o         = s_bus_addr_q;
    assign s_bus_wr_data_o      = s_bus_wr_data_q;
    assign s_bus_wr_biten_o     = s_bus_wr_biten_q;
    assign s_bus_req_stall_wr_o = stall_q;
    assign s_bus_req_stall_rd_o = stall_q;

endmodule

// File: doc/bus2reg_arbiter.md
Name: bus2reg_arbiter

Overview:
- Shares one register-map access port (Bus2Reg BUS-side signal set) between NUM_REQ upstream requesters, e.g. the AXI4-Lite adapter, a debug/JTAG bridge and an internal config sequencer.
- Uses round-robin arbitration with one outstanding transaction at a time.
- Runs a response-timeout watchdog so a silent register map cannot hang any requester.
- Sits between the bus adapters and the register map.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 32, data and bit-enable width.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 256, WAIT cycles before forced error completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  NUM_REQ  per-requester request level; held until that requester's m_ready.
- m_req_is_wr  in  NUM_REQ  1 = write, 0 = read.
- m_addr  in  NUM_REQ x ADDR_WIDTH  request address.
- m_wr_data  in  NUM_REQ x DATA_WIDTH  write data.
- m_wr_biten  in  NUM_REQ x DATA_WIDTH  write bit enables.
- m_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- m_rd_data  out  DATA_WIDTH  read data (shared), valid with m_ready.
- m_err  out  1  error flag (shared), valid with m_ready.
- s_bus_req  out  1  one-cycle request to the register map.
- s_bus_req_is_wr, s_bus_addr, s_bus_wr_data, s_bus_wr_biten  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH  registered request attributes.
- s_bus_req_stall_wr, s_bus_req_stall_rd  out  1  high while a transaction is outstanding (ISSUE or WAIT).
- s_bus_ready  in  1  register-map completion.
- s_bus_rd_data  in  DATA_WIDTH  register-map read data.
- s_bus_err  in  1  register-map error.

Behaviour:
- Reset: every output is 0, FSM is in IDLE, the round-robin pointer is NUM_REQ-1 (requester 0 has first priority), and the timeout counter is 0. Reset asserted mid-transaction aborts immediately; no m_ready is produced for the aborted transaction.
- Requester contract: attributes stay stable while m_req[i] is high. The requester drops m_req[i] on the edge where it samples m_ready[i]. A requester that keeps m_req high after m_ready is treated as issuing a new request.
- Arbitration: searches from pointer+1 upward, modulo NUM_REQ; the first requester found wins. On grant, the pointer is set to the winner. Requests arriving during a transaction wait; arbitration is evaluated only in IDLE.
- FSM states:
  - IDLE: if any m_req is high, register the winner index and its attributes onto the s_bus_* attribute regs, then go to ISSUE.
  - ISSUE: s_bus_req=1 for exactly one cycle. If s_bus_ready=1 in this same cycle, capture the response and go to RESP; otherwise go to WAIT.
  - WAIT: the timeout counter increments each cycle. On s_bus_ready, capture s_bus_rd_data/s_bus_err and go to RESP. If the counter reaches TIMEOUT_CYCLES without ready, capture rd_data=0, err=1 and go to RESP. If ready and timeout occur in the same cycle, ready wins.
  - RESP: m_ready[grant]=1 for one cycle with m_rd_data/m_err driven from the captured values. Then go to IDLE and clear the counter.
- Latency: request seen in IDLE at cycle 0, s_bus_req at cycle 1. m_ready comes 1 cycle after s_bus_ready, so the minimum is 3 cycles (IDLE, ISSUE with ready, RESP).
- s_bus_ready outside ISSUE/WAIT is ignored. The s_bus_* attributes hold their last value between transactions.
- m_rd_data and m_err are 0 whenever m_ready is low.
- Writes return m_rd_data = s_bus_rd_data as received; the arbiter does not mask it.
- The timeout counter width is $clog2(TIMEOUT_CYCLES+1). With TIMEOUT_CYCLES=0, WAIT has no exit except ready.

Decomposition:
- Package bus2reg_arb_pkg holds: the state enum typedef (IDLE, ISSUE, WAIT, RESP), the request struct typedef (is_wr, addr, wr_data, wr_biten) and a DEFAULT_TIMEOUT constant.
- One sub-module, rr_arbiter: a combinational round-robin winner from req vector and pointer, outputting a one-hot grant and an index. It is reusable elsewhere in the design.

Test Plan:
- Single read: requester 0 reads 0x10; map returns 0xDEADBEEF with ready 2 cycles after s_bus_req -> s_bus_req one cycle with addr 0x10, is_wr=0; m_ready[0] pulses with m_rd_data=0xDEADBEEF, m_err=0; no pulse on m_ready[1].
- Contention: both requesters held continuously for 4 transactions -> grant order 0,1,0,1; s_bus_req never high while a transaction is outstanding.
- Zero-latency map: s_bus_ready high in the same cycle as s_bus_req -> m_ready on the next cycle, 3 cycles after the request.
- Timeout: TIMEOUT_CYCLES=8, map never responds to a write from requester 1 -> m_ready[1] with m_err=1 and m_rd_data=0. Bench checks the exact pulse cycle (WAIT has 8 cycles), then the arbiter returns to IDLE and serves requester 0.
- Ready/timeout collision: s_bus_ready asserted exactly in the timeout cycle -> m_err reflects s_bus_err=0 and returned data is kept.
- Reset mid-WAIT: rst pulsed during an outstanding read -> all outputs 0, no m_ready. After release, the next request is granted to requester 0 first.
